multicycle_control: RTL and testbench

//  Multi-cycle MIPS control unit; successor to the single-cycle opcode decoder. Moore FSM sequences

---
 rtl/multicycle_control.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control unit. A Moore FSM steps each instruction through
//    FETCH/DECODE/EXEC/MEM/WB over one shared memory port. It counts retired instructions and flags
//    illegal opcodes and memory timeouts.
// Latency (cycles incl. FETCH, no memory wait): R 4, lw 5, sw 4, beq 3, j 3, imm 4.
// Backpressure: FETCH/MEMRD/MEMWR hold until MemReady_i. Each non-ready cycle adds one cycle.
//    After MEM_TIMEOUT non-ready cycles the access is abandoned (MemErr_o) and the FSM refetches.
//
// Optional feature macro: IMM_ALU_EN. When it is defined, addi/andi/ori execute through
//    IMMEX/IMMWB. When it is undefined, those opcodes decode as illegal.
//
// Parameters:
//    MEM_TIMEOUT : max non-ready cycles per memory access (0 = wait forever)
//    CNT_W       : width of InstrCount_o
// Ports:
//    clk_i, rst_i           : clock, synchronous active-high reset
//    Op_i                   : IR opcode field, sampled in DECODE
//    Zero_i                 : ALU zero flag for beq
//    MemReady_i             : memory completes the current access this cycle
//    PCWrite_o, IRWrite_o   : PC / IR load strobes
//    IorD_o, MemRead_o, MemWrite_o              : memory port address select and requests
//    RegDst_o, MemtoReg_o, RegWrite_o           : register-file write control
//    ALUSrcA_o, ALUSrcB_o, ALUOp_o, ExtOp_o     : ALU operand/operation select
//    PCSource_o             : next-PC select
//    State_o                : current FSM state (debug)
//    Illegal_o, MemErr_o    : one-cycle error pulses
//    InstrCount_o           : retired instruction count (wraps)

module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       Op_i,
   input  logic             Zero_i,
   input  logic             MemReady_i,
   output logic             PCWrite_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             RegDst_o,
   output logic             MemtoReg_o,
   output logic             RegWrite_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic [1:0]       PCSource_o,
   output logic             ExtOp_o,
   output logic [3:0]       State_o,
   output logic             Illegal_o,
   output logic             MemErr_o,
   output logic [CNT_W-1:0] InstrCount_o
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef IMM_ALU_EN
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

   // Wait counter must be able to hold MEM_TIMEOUT itself.
   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IMMEX  = 4'd10,
      S_IMMWB  = 4'd11
   } state_t;

   // Moore part of the control word. It is registered from the next state, so the
   // outputs come straight from flops.
   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       ext_op;
      logic       pc_write_u;   // unconditional PC write (jump)
   } ctrl_t;

   // imm_logical: the latched opcode is andi/ori (zero-extended immediate, logical ALU op).
   function automatic ctrl_t decode_ctrl(input state_t s, input logic imm_logical);
      ctrl_t c;
      c        = '0;
      c.ext_op = ~imm_logical;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'd1;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
            c.alu_op    = 2'd1;
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = 2'd1;
         end
         S_MEMRD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'd0;
         end
         S_ALUWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'd2;
            c.pc_source = 2'b01;
         end
         S_JUMP: begin
            c.pc_source  = 2'b10;
            c.pc_write_u = 1'b1;
         end
         S_IMMEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_op    = imm_logical ? 2'd3 : 2'd1;
         end
         S_IMMWB: begin
            c.reg_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t           r_state;
   logic [5:0]       r_op;
   logic [TW-1:0]    r_wait;
   logic [CNT_W-1:0] r_count;
   ctrl_t            r_ctrl;

   state_t     w_state_nxt;
   logic [5:0] w_op_nxt;
   logic       w_imm_logical_nxt;
   logic       w_mem_state;
   logic       w_timeout;
   logic       w_illegal;
   logic       w_retire;
   logic       w_fetch_done;
   logic       w_run;

   assign w_op_nxt = (r_state == S_DECODE) ? Op_i : r_op;

`ifdef IMM_ALU_EN
   assign w_imm_logical_nxt = (w_op_nxt == OP_ANDI) || (w_op_nxt == OP_ORI);
`else
   assign w_imm_logical_nxt = 1'b0;
`endif

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

   // A ready in the timeout cycle completes the access, so readiness is checked first.
   assign w_timeout = (MEM_TIMEOUT != 0) && w_mem_state && !MemReady_i &&
                      (r_wait == TW'(MEM_TIMEOUT));

   always_comb begin
      w_state_nxt = r_state;
      w_illegal   = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         S_FETCH:  if (MemReady_i) w_state_nxt = S_DECODE;
         S_DECODE: begin
            case (Op_i)
               OP_LW, OP_SW: w_state_nxt = S_MEMADR;
               OP_R:         w_state_nxt = S_EXEC;
               OP_BEQ:       w_state_nxt = S_BRANCH;
               OP_J:         w_state_nxt = S_JUMP;
`ifdef IMM_ALU_EN
               OP_ADDI, OP_ANDI, OP_ORI: w_state_nxt = S_IMMEX;
`endif
               default: begin
                  w_illegal   = 1'b1;
                  w_state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMADR: w_state_nxt = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (MemReady_i)     w_state_nxt = S_MEMWB;
            else if (w_timeout) w_state_nxt = S_FETCH;
         end
         S_MEMWR: begin
            if (MemReady_i) begin
               w_state_nxt = S_FETCH;
               w_retire    = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_EXEC:  w_state_nxt = S_ALUWB;
         S_IMMEX: w_state_nxt = S_IMMWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB: begin
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_FETCH;
         r_op    <= '0;
         r_wait  <= '0;
         r_count <= '0;
         r_ctrl  <= decode_ctrl(S_FETCH, 1'b0);
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_ctrl  <= decode_ctrl(w_state_nxt, w_imm_logical_nxt);
         // A timed-out FETCH re-enters FETCH without a state change, so it clears explicitly.
         if (w_timeout || (w_state_nxt != r_state))
            r_wait <= '0;
         else if (w_mem_state && !MemReady_i)
            r_wait <= r_wait + TW'(1);
         if (w_retire)
            r_count <= r_count + CNT_W'(1);
      end
   end

   // Strobes and pulses are forced low for as long as reset is held, including the
   // cycle in which it is first asserted.
   assign w_run        = ~rst_i;
   assign w_fetch_done = (r_state == S_FETCH) && MemReady_i;

   assign PCWrite_o    = w_run & (r_ctrl.pc_write_u | w_fetch_done |
                                  ((r_state == S_BRANCH) & Zero_i));
   assign IRWrite_o    = w_run & w_fetch_done;
   assign MemRead_o    = w_run & r_ctrl.mem_read;
   assign MemWrite_o   = w_run & r_ctrl.mem_write;
   assign RegWrite_o   = w_run & r_ctrl.reg_write;
   assign Illegal_o    = w_run & w_illegal;
   assign MemErr_o     = w_run & w_timeout;

   assign IorD_o       = r_ctrl.iord;
   assign RegDst_o     = r_ctrl.reg_dst;
   assign MemtoReg_o   = r_ctrl.mem_to_reg;
   assign ALUSrcA_o    = r_ctrl.alu_src_a;
   assign ALUSrcB_o    = r_ctrl.alu_src_b;
   assign ALUOp_o      = r_ctrl.alu_op;
   assign PCSource_o   = r_ctrl.pc_source;
   assign ExtOp_o      = r_ctrl.ext_op;
   assign State_o      = r_state;
   assign InstrCount_o = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed cycle-by-cycle bench for multicycle_control.
// Latency: n/a (bench).
// Backpressure: MemReady_i is driven per cycle from the vectors below.

module tb_multicycle_control;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_BAD = 6'b111111;

   logic        clk = 1'b0;
   logic        rst, zero, ready;
   logic [5:0]  op;
   logic        PCWrite_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o;
   logic        RegWrite_o, ALUSrcA_o, ExtOp_o, Illegal_o, MemErr_o;
   logic [1:0]  ALUSrcB_o, ALUOp_o, PCSource_o;
   logic [3:0]  State_o;
   logic [31:0] InstrCount_o;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .Op_i(op), .Zero_i(zero), .MemReady_i(ready),
      .PCWrite_o(PCWrite_o), .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .IRWrite_o(IRWrite_o), .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o),
      .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
      .ALUOp_o(ALUOp_o), .PCSource_o(PCSource_o), .ExtOp_o(ExtOp_o), .State_o(State_o),
      .Illegal_o(Illegal_o), .MemErr_o(MemErr_o), .InstrCount_o(InstrCount_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock: drive this cycle's inputs just after the edge, let them settle, check state.
   task automatic rc(input logic rdy, input logic z, input logic [5:0] o,
                     input logic [3:0] exp_st, input string tag);
      @(posedge clk);
      #1;
      ready = rdy;
      zero  = z;
      op    = o;
      #1;
      chk({tag, "_state"}, {28'd0, State_o}, {28'd0, exp_st});
   endtask

   initial begin
      rst   = 1'b1;
      zero  = 1'b0;
      ready = 1'b1;
      op    = OP_R;

      // Reset
      @(posedge clk); @(posedge clk); #2;
      chk("rst_state",   {28'd0, State_o}, 32'd0);
      chk("rst_memread", {31'd0, MemRead_o}, 32'd0);
      chk("rst_irwrite", {31'd0, IRWrite_o}, 32'd0);
      chk("rst_count",   InstrCount_o, 32'd0);

      // R-type, ready tied high: 0,1,6,7,0
      @(posedge clk); #1;
      rst = 1'b0; ready = 1'b1; op = OP_R;
      #1;
      chk("r_fetch_state", {28'd0, State_o}, 32'd0);
      chk("r_fetch_memrd", {31'd0, MemRead_o}, 32'd1);
      chk("r_fetch_irwr",  {31'd0, IRWrite_o}, 32'd1);
      chk("r_fetch_pcwr",  {31'd0, PCWrite_o}, 32'd1);
      chk("r_fetch_srcb",  {30'd0, ALUSrcB_o}, 32'd1);
      chk("r_fetch_aluop", {30'd0, ALUOp_o}, 32'd1);
      rc(1, 0, OP_R, 4'd1, "r_dec");
      chk("r_dec_srcb", {30'd0, ALUSrcB_o}, 32'd3);
      chk("r_dec_regwr", {31'd0, RegWrite_o}, 32'd0);
      rc(1, 0, OP_R, 4'd6, "r_exec");
      chk("r_exec_aluop", {30'd0, ALUOp_o}, 32'd0);
      chk("r_exec_srca", {31'd0, ALUSrcA_o}, 32'd1);
      chk("r_exec_regwr", {31'd0, RegWrite_o}, 32'd0);
      rc(1, 0, OP_R, 4'd7, "r_wb");
      chk("r_wb_regwr", {31'd0, RegWrite_o}, 32'd1);
      chk("r_wb_regdst", {31'd0, RegDst_o}, 32'd1);

      // lw, two wait cycles on each access: 9 cycles total
      rc(0, 0, OP_LW, 4'd0, "lw_f1");
      chk("r_count", InstrCount_o, 32'd1);
      chk("lw_f1_irwr", {31'd0, IRWrite_o}, 32'd0);
      chk("lw_f1_regdst", {31'd0, RegDst_o}, 32'd0);
      rc(0, 0, OP_LW, 4'd0, "lw_f2");
      rc(1, 0, OP_LW, 4'd0, "lw_f3");
      chk("lw_f3_irwr", {31'd0, IRWrite_o}, 32'd1);
      rc(1, 0, OP_LW, 4'd1, "lw_dec");
      rc(1, 0, OP_LW, 4'd2, "lw_adr");
      chk("lw_adr_srcb", {30'd0, ALUSrcB_o}, 32'd2);
      rc(0, 0, OP_LW, 4'd3, "lw_rd1");
      chk("lw_rd1_iord", {31'd0, IorD_o}, 32'd1);
      chk("lw_rd1_memrd", {31'd0, MemRead_o}, 32'd1);
      rc(0, 0, OP_LW, 4'd3, "lw_rd2");
      rc(1, 0, OP_LW, 4'd3, "lw_rd3");
      rc(1, 0, OP_LW, 4'd4, "lw_wb");
      chk("lw_wb_m2r", {31'd0, MemtoReg_o}, 32'd1);
      chk("lw_wb_regwr", {31'd0, RegWrite_o}, 32'd1);

      // beq not taken, then taken
      rc(1, 0, OP_BEQ, 4'd0, "beq0_f");
      chk("lw_count", InstrCount_o, 32'd2);
      rc(1, 0, OP_BEQ, 4'd1, "beq0_dec");
      rc(1, 0, OP_BEQ, 4'd8, "beq0_br");
      chk("beq0_pcwr", {31'd0, PCWrite_o}, 32'd0);
      chk("beq0_aluop", {30'd0, ALUOp_o}, 32'd2);
      rc(1, 1, OP_BEQ, 4'd0, "beq1_f");
      rc(1, 1, OP_BEQ, 4'd1, "beq1_dec");
      rc(1, 1, OP_BEQ, 4'd8, "beq1_br");
      chk("beq1_pcwr", {31'd0, PCWrite_o}, 32'd1);
      chk("beq1_pcsrc", {30'd0, PCSource_o}, 32'd1);

      // Illegal opcode
      rc(1, 0, OP_BAD, 4'd0, "ill_f");
      chk("beq_count", InstrCount_o, 32'd4);
      rc(1, 0, OP_BAD, 4'd1, "ill_dec");
      chk("ill_pulse", {31'd0, Illegal_o}, 32'd1);

      // sw with memory timeout in MEMWR (MEM_TIMEOUT=4)
      rc(1, 0, OP_SW, 4'd0, "swt_f");
      chk("ill_count", InstrCount_o, 32'd4);
      chk("ill_clear", {31'd0, Illegal_o}, 32'd0);
      rc(1, 0, OP_SW, 4'd1, "swt_dec");
      rc(1, 0, OP_SW, 4'd2, "swt_adr");
      for (int i = 0; i < 4; i++) begin
         rc(0, 0, OP_SW, 4'd5, "swt_wait");
         chk("swt_wait_memwr", {31'd0, MemWrite_o}, 32'd1);
         chk("swt_wait_err", {31'd0, MemErr_o}, 32'd0);
      end
      rc(0, 0, OP_SW, 4'd5, "swt_to");
      chk("swt_to_err", {31'd0, MemErr_o}, 32'd1);

      // sw where ready arrives in the timeout cycle: normal completion
      rc(1, 0, OP_SW, 4'd0, "swr_f");
      chk("swt_memwr_drop", {31'd0, MemWrite_o}, 32'd0);
      chk("swt_count", InstrCount_o, 32'd4);
      rc(1, 0, OP_SW, 4'd1, "swr_dec");
      rc(1, 0, OP_SW, 4'd2, "swr_adr");
      for (int i = 0; i < 4; i++) rc(0, 0, OP_SW, 4'd5, "swr_wait");
      rc(1, 0, OP_SW, 4'd5, "swr_rdy");
      chk("swr_rdy_err", {31'd0, MemErr_o}, 32'd0);

      // j
      rc(1, 0, OP_J, 4'd0, "j_f");
      chk("swr_count", InstrCount_o, 32'd5);
      rc(1, 0, OP_J, 4'd1, "j_dec");
      rc(1, 0, OP_J, 4'd9, "j_jmp");
      chk("j_pcwr", {31'd0, PCWrite_o}, 32'd1);
      chk("j_pcsrc", {30'd0, PCSource_o}, 32'd2);

      // ori
      rc(1, 0, OP_ORI, 4'd0, "ori_f");
      chk("j_count", InstrCount_o, 32'd6);
      rc(1, 0, OP_ORI, 4'd1, "ori_dec");
`ifdef IMM_ALU_EN
      chk("ori_illegal", {31'd0, Illegal_o}, 32'd0);
      rc(1, 0, OP_ORI, 4'd10, "ori_ex");
      chk("ori_aluop", {30'd0, ALUOp_o}, 32'd3);
      chk("ori_extop", {31'd0, ExtOp_o}, 32'd0);
      chk("ori_srcb", {30'd0, ALUSrcB_o}, 32'd2);
      rc(1, 0, OP_ORI, 4'd11, "ori_wb");
      chk("ori_regwr", {31'd0, RegWrite_o}, 32'd1);
      rc(1, 0, OP_ORI, 4'd0, "post_ori_f");
      chk("ori_count", InstrCount_o, 32'd7);
`else
      chk("ori_illegal", {31'd0, Illegal_o}, 32'd1);
      rc(1, 0, OP_ORI, 4'd0, "post_ori_f");
      chk("ori_count", InstrCount_o, 32'd6);
      chk("ori_extop", {31'd0, ExtOp_o}, 32'd1);
`endif

      // Reset asserted while waiting in MEMRD
      rc(1, 0, OP_LW, 4'd1, "rlw_dec");
      rc(1, 0, OP_LW, 4'd2, "rlw_adr");
      rc(0, 0, OP_LW, 4'd3, "rlw_rd");
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rlw_rstcyc_memrd", {31'd0, MemRead_o}, 32'd0);
      @(posedge clk); #2;
      chk("rlw_state",   {28'd0, State_o}, 32'd0);
      chk("rlw_memrd",   {31'd0, MemRead_o}, 32'd0);
      chk("rlw_irwr",    {31'd0, IRWrite_o}, 32'd0);
      chk("rlw_pcwr",    {31'd0, PCWrite_o}, 32'd0);
      chk("rlw_regwr",   {31'd0, RegWrite_o}, 32'd0);
      chk("rlw_count",   InstrCount_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rel_state", {28'd0, State_o}, 32'd0);
      chk("rel_memrd", {31'd0, MemRead_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
